// File: rtl/wrapper_packet_framer_buffer.sv
// wrapper_packet_framer_buffer: frames an unframed packet stream into blocks and buffers it in a FIFO
// with last/remain sideband for the downstream deconstructor.
module wrapper_packet_framer_buffer #(
  parameter int ADDRWIDTH = 11,
  parameter int PACKETWIDTH = 256,
  parameter int DEPTH = 4,
  localparam int PSW = ADDRWIDTH - $clog2(PACKETWIDTH/8),
  localparam int MAXBLK = 2**PSW,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   flush,
  input  logic [PSW:0]           block_packets,
  input  logic [PACKETWIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [PACKETWIDTH-1:0] packet_data,
  output logic                   packet_data_last,
  output logic [PSW-1:0]         packet_data_remain,
  output logic                   packet_data_valid,
  input  logic                   packet_data_ready,
  output logic [LW-1:0]          fifo_level,
  output logic                   block_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW1 = PSW + 1;
  localparam int EW = PACKETWIDTH + PSW + 1;
  localparam logic [PSW:0] MAXB = PW1'(MAXBLK);
  typedef enum logic {IDLE, IN_BLK} state_t;
  state_t         state_q, state_d;
  logic [PSW-1:0] idx_q, idx_d;
  logic [PSW:0]   blk_len_q, blk_len_d, clamp, len, len_m1;
  logic [LW-1:0]  level_q, level_d;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic           rdy_q, done_q, done_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  head;
  logic [PSW-1:0] remain;
  logic           push, pop, last;
  always_comb begin
    clamp = block_packets == '0 ? PW1'(1) : (block_packets > MAXB ? MAXB : block_packets);
    len = state_q == IDLE ? clamp : blk_len_q;
    len_m1 = len - PW1'(1);
    last = len_m1 == {1'b0, idx_q};
    remain = PSW'(len_m1 - {1'b0, idx_q});
    // in_ready stays low until one clock after reset release
    in_ready = rdy_q && level_q != LW'(DEPTH) && !flush;
    packet_data_valid = level_q != '0;
    head = mem_q[rd_q];
    packet_data = packet_data_valid ? head[PACKETWIDTH-1:0] : '0;
    packet_data_remain = packet_data_valid ? head[EW-2:PACKETWIDTH] : '0;
    packet_data_last = packet_data_valid && head[EW-1];
    fifo_level = level_q;
    block_done = done_q;
    push = in_valid && in_ready;
    pop = packet_data_valid && packet_data_ready;
    state_d = state_q;
    idx_d = idx_q;
    blk_len_d = blk_len_q;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
    done_d = pop && head[EW-1];
    if (push) begin
      blk_len_d = len;
      idx_d = last ? '0 : idx_q + PSW'(1);
      state_d = last ? IDLE : IN_BLK;
    end
    if (flush) begin
      state_d = IDLE;
      idx_d = '0;
      wr_d = '0;
      rd_d = '0;
      level_d = '0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      blk_len_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      done_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      blk_len_q <= blk_len_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      done_q <= done_d;
      rdy_q <= 1'b1;
    end
  end
  always_ff @(posedge hclk) begin
    if (push) mem_q[wr_q] <= {last, remain, in_data};
  end
endmodule

// File: tb/tb_wrapper_packet_framer_buffer.sv
// tb_wrapper_packet_framer_buffer: directed and random stimulus against a queue-based framing model.
module tb_wrapper_packet_framer_buffer;
  localparam int PW = 256;
  localparam int DEPTH = 4;
  localparam int MAXBLK = 64;
  typedef struct {
    logic [PW-1:0] data;
    logic          last;
    int            rem;
  } ent_t;
  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          flush = 1'b0;
  logic [6:0]    block_packets = '0;
  logic [PW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] packet_data;
  logic          packet_data_last;
  logic [5:0]    packet_data_remain;
  logic          packet_data_valid;
  logic          packet_data_ready = 1'b0;
  logic [2:0]    fifo_level;
  logic          block_done;
  ent_t q[$];
  int   pos = 0;
  int   cur_len = 1;
  bit   started = 0;
  bit   done_exp = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  wrapper_packet_framer_buffer #(.ADDRWIDTH(11), .PACKETWIDTH(PW), .DEPTH(DEPTH)) dut (
    .hclk(hclk), .hresetn(hresetn), .flush(flush), .block_packets(block_packets),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .packet_data(packet_data), .packet_data_last(packet_data_last),
    .packet_data_remain(packet_data_remain), .packet_data_valid(packet_data_valid),
    .packet_data_ready(packet_data_ready), .fifo_level(fifo_level), .block_done(block_done)
  );
  always #5 hclk = ~hclk;
  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int clamp_len(input int bp);
    return bp == 0 ? 1 : (bp > MAXBLK ? MAXBLK : bp);
  endfunction
  task automatic model_clear();
    q.delete();
    pos = 0;
    done_exp = 0;
  endtask
  // Inputs change on the falling edge; outputs are checked 1ns later and the model advances on the rising edge.
  task automatic step(input logic v, input logic r, input logic f, input int bp);
    bit exp_rdy, push, pop;
    ent_t e;
    in_valid = v;
    packet_data_ready = r;
    flush = f;
    block_packets = 7'(bp);
    in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1;
    exp_rdy = started && hresetn && q.size() < DEPTH && !f;
    chk("in_ready", PW'(in_ready), PW'(exp_rdy));
    chk("valid", PW'(packet_data_valid), PW'(q.size() != 0));
    chk("level", PW'(fifo_level), PW'(q.size()));
    chk("block_done", PW'(block_done), PW'(done_exp));
    if (q.size() != 0) begin
      chk("data", packet_data, q[0].data);
      chk("last", PW'(packet_data_last), PW'(q[0].last));
      chk("remain", PW'(packet_data_remain), PW'(q[0].rem));
    end
    push = v && exp_rdy;
    pop = q.size() != 0 && r;
    @(posedge hclk);
    if (!hresetn) begin
      model_clear();
      started = 0;
    end else if (f) begin
      model_clear();
      started = 1;
    end else begin
      started = 1;
      done_exp = pop && q[0].last;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (pos == 0) cur_len = clamp_len(bp);
        e.data = in_data;
        e.rem = cur_len - 1 - pos;
        e.last = pos == cur_len - 1;
        pos = e.last ? 0 : pos + 1;
        q.push_back(e);
      end
    end
    @(negedge hclk);
  endtask
  task automatic drain(input int bp);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0, bp);
  endtask
  initial begin
    @(negedge hclk);
    step(0, 0, 0, 3);
    step(1, 1, 0, 3);
    hresetn = 1'b1;
    step(1, 1, 0, 3);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 3);
    drain(3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    drain(0);
    for (int i = 0; i < 66; i++) step(1, 1, 0, 100);
    drain(4);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 4);
    step(1, 1, 0, 4);
    step(1, 0, 0, 4);
    step(0, 0, 0, 4);
    drain(4);
    step(1, 1, 0, 4);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 2);
    drain(2);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 4);
    step(1, 0, 1, 4);
    step(0, 0, 0, 4);
    step(1, 0, 0, 4);
    drain(4);
    step(1, 1, 1, 4);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 5);
    hresetn = 1'b0;
    model_clear();
    started = 0;
    step(0, 0, 0, 5);
    step(1, 1, 0, 5);
    hresetn = 1'b1;
    step(1, 1, 0, 5);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3);
    for (int i = 0; i < 3000; i++) begin
      int bp;
      bp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
      step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, bp);
    end
    drain(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
